// File: rtl/int_sched.sv
// int_sched: latches, masks and prioritises six interrupt lines for the CPU and counts accepted interrupts.
// Optional macro INTC_PRIORITY_EN presents only the winning source on HWInt.
module int_sched #(
  parameter int               NSRC       = 6,
  parameter logic [NSRC-1:0]  RESET_MASK = 6'h3F,
  parameter logic [NSRC-1:0]  RESET_EDGE = 6'h00
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic            Intrespon,
  input  logic [1:0]      Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  output logic [NSRC-1:0] HWInt
);

  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_edge;
  logic [NSRC-1:0] r_src_q;
  logic [15:0]     r_ackcnt;

  logic [NSRC-1:0] w_act;
  logic            w_valid;
  logic [2:0]      w_id;
  logic [NSRC-1:0] w_id_onehot;
  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_pend_nxt;
  logic            w_ack;
  logic            w_wr_pend;
  logic            w_wr_mask;
  logic            w_wr_edge;
  logic            w_wr_stat;
  logic            w_din_unused;

  assign w_act     = r_pend & r_mask;
  assign w_rise    = irq_src & ~r_src_q;
  assign w_ack     = Intrespon & w_valid;
  assign w_wr_pend = WE && (Addr == 2'd0);
  assign w_wr_mask = WE && (Addr == 2'd1);
  assign w_wr_edge = WE && (Addr == 2'd2);
  assign w_wr_stat = WE && (Addr == 2'd3);
  assign w_din_unused = ^Din[31:NSRC];

  // Lowest set index of the enabled pending vector wins.
  always_comb begin
    w_valid = |w_act;
    w_id    = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      w_id = w_act[i] ? 3'(i) : w_id;
    end
    w_id_onehot = w_valid ? ({{(NSRC-1){1'b0}}, 1'b1} << w_id) : {NSRC{1'b0}};
  end

  // Edge bits: a new edge beats any clear; level bits simply follow the source.
  assign w_clr      = (w_wr_pend ? Din[NSRC-1:0] : {NSRC{1'b0}})
                    | (w_ack ? w_id_onehot : {NSRC{1'b0}});
  assign w_pend_nxt = (r_edge & (w_rise | (r_pend & ~w_clr))) | (~r_edge & irq_src);

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend   <= {NSRC{1'b0}};
      r_mask   <= RESET_MASK;
      r_edge   <= RESET_EDGE;
      r_src_q  <= {NSRC{1'b0}};
      r_ackcnt <= 16'h0000;
    end else begin
      r_pend  <= w_pend_nxt;
      r_src_q <= irq_src;
      if (w_wr_mask) begin
        r_mask <= Din[NSRC-1:0];
      end
      if (w_wr_edge) begin
        r_edge <= Din[NSRC-1:0];
      end
      if (w_wr_stat) begin
        r_ackcnt <= 16'h0000;
      end else if (w_ack && (r_ackcnt != 16'hFFFF)) begin
        r_ackcnt <= r_ackcnt + 16'd1;
      end
    end
  end

  // Register read mux.
  always_comb begin
    Dout = 32'h0000_0000;
    case (Addr)
      2'd0:    Dout = {{(32-NSRC){1'b0}}, r_pend};
      2'd1:    Dout = {{(32-NSRC){1'b0}}, r_mask};
      2'd2:    Dout = {{(32-NSRC){1'b0}}, r_edge};
      2'd3:    Dout = {r_ackcnt, 12'h000, w_valid, w_id};
      default: Dout = 32'h0000_0000;
    endcase
  end

`ifdef INTC_PRIORITY_EN
  assign HWInt = w_id_onehot;
`else
  assign HWInt = w_act;
`endif

endmodule

// File: tb/tb_int_sched.sv
// tb_int_sched: directed and random checks of int_sched against a behavioural register model.
module tb_int_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  irq_src = 6'h00;
  logic        Intrespon = 1'b0;
  logic [1:0]  Addr = 2'd0;
  logic        WE = 1'b0;
  logic [31:0] Din = 32'h0;
  logic [31:0] Dout;
  logic [5:0]  HWInt;

  int vectors = 0;
  int miscompares = 0;

  logic [5:0] m_pend, m_mask, m_edge, m_srcq;
  int         m_ack;
  bit         m_init = 1'b0;

  int_sched dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .Intrespon(Intrespon),
    .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout), .HWInt(HWInt)
  );

  always #5 clk = ~clk;

  function automatic int lowest(input logic [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    int l;
    l = lowest(m_pend & m_mask);
    case (a)
      2'd0:    return {26'd0, m_pend};
      2'd1:    return {26'd0, m_mask};
      2'd2:    return {26'd0, m_edge};
      default: return {m_ack[15:0], 12'd0, (l >= 0), (l >= 0) ? 3'(l) : 3'd0};
    endcase
  endfunction

  function automatic logic [5:0] m_hw();
`ifdef INTC_PRIORITY_EN
    int l;
    l = lowest(m_pend & m_mask);
    return (l >= 0) ? 6'(1 << l) : 6'h00;
`else
    return m_pend & m_mask;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model of one rising edge, written from the register rules.
  task automatic model_edge(input logic [5:0] src, input bit ir, input logic [1:0] a,
                            input bit we, input logic [31:0] din, input bit rst);
    logic [5:0] np;
    int l;
    if (rst) begin
      m_pend = 6'h00; m_mask = 6'h3F; m_edge = 6'h00; m_srcq = 6'h00; m_ack = 0; m_init = 1'b1;
    end else begin
      l = lowest(m_pend & m_mask);
      for (int i = 0; i < 6; i++) begin
        if (m_edge[i]) begin
          if (src[i] && !m_srcq[i]) np[i] = 1'b1;
          else if ((we && a == 2'd0 && din[i]) || (ir && l == i)) np[i] = 1'b0;
          else np[i] = m_pend[i];
        end else begin
          np[i] = src[i];
        end
      end
      if (we && a == 2'd3) m_ack = 0;
      else if (ir && l >= 0 && m_ack < 65535) m_ack = m_ack + 1;
      if (we && a == 2'd1) m_mask = din[5:0];
      if (we && a == 2'd2) m_edge = din[5:0];
      m_srcq = src;
      m_pend = np;
    end
  endtask

  task automatic step(input logic [5:0] src, input bit ir, input logic [1:0] a,
                      input bit we, input logic [31:0] din, input bit rst);
    irq_src = src; Intrespon = ir; Addr = a; WE = we; Din = din; reset = rst;
    #1;
    if (m_init) check("dout", Dout, m_read(a));
    @(posedge clk);
    model_edge(src, ir, a, we, din, rst);
    #1;
    check("hwint", {26'd0, HWInt}, {26'd0, m_hw()});
  endtask

  task automatic peek(input logic [1:0] a, input logic [31:0] exp, input string tag);
    Addr = a;
    #1;
    check(tag, Dout, exp);
  endtask

  initial begin
    logic [5:0] rs;
    // Reset and level source
    step(6'h00, 0, 2'd0, 0, 32'h0, 1);
    step(6'h00, 0, 2'd0, 0, 32'h0, 1);
    check("rst_hwint", {26'd0, HWInt}, 32'h0);
    peek(2'd1, 32'h0000_003F, "rst_mask");
    peek(2'd3, 32'h0000_0000, "rst_stat");
    step(6'h01, 0, 2'd0, 0, 32'h0, 0);
    check("lvl_on", {26'd0, HWInt}, 32'h01);
    peek(2'd3, 32'h0000_0008, "lvl_stat");
    step(6'h00, 0, 2'd0, 0, 32'h0, 0);
    check("lvl_off", {26'd0, HWInt}, 32'h00);

    // Edge latch and W1C
    step(6'h00, 0, 2'd2, 1, 32'h4, 0);
    step(6'h04, 0, 2'd0, 0, 32'h0, 0);
    step(6'h00, 0, 2'd0, 0, 32'h0, 0);
    step(6'h00, 0, 2'd0, 0, 32'h0, 0);
    peek(2'd0, 32'h4, "edge_hold");
    check("edge_hw", {26'd0, HWInt}, 32'h04);
    step(6'h00, 0, 2'd0, 1, 32'h4, 0);
    peek(2'd0, 32'h0, "w1c");

    // Two edge sources, auto-ack
    step(6'h00, 0, 2'd2, 1, 32'h3, 0);
    step(6'h03, 0, 2'd0, 0, 32'h0, 0);
    step(6'h00, 0, 2'd0, 0, 32'h0, 0);
`ifdef INTC_PRIORITY_EN
    check("two_hw", {26'd0, HWInt}, 32'h01);
`else
    check("two_hw", {26'd0, HWInt}, 32'h03);
`endif
    step(6'h00, 1, 2'd0, 0, 32'h0, 0);
    peek(2'd0, 32'h2, "ack1_pend");
    check("ack1_hw", {26'd0, HWInt}, 32'h02);
    peek(2'd3, 32'h0001_0009, "ack1_stat");
    step(6'h00, 1, 2'd0, 0, 32'h0, 0);
    peek(2'd0, 32'h0, "ack2_pend");
    peek(2'd3, 32'h0002_0000, "ack2_stat");

    // Masking
    step(6'h00, 0, 2'd2, 1, 32'h0, 0);
    step(6'h01, 0, 2'd1, 1, 32'h3E, 0);
    step(6'h01, 0, 2'd0, 0, 32'h0, 0);
    check("masked_hw", {26'd0, HWInt}, 32'h00);
    peek(2'd3, 32'h0002_0000, "masked_stat");
    step(6'h01, 0, 2'd1, 1, 32'h3F, 0);
    check("unmask_hw", {26'd0, HWInt}, 32'h01);

    // Edge set beats W1C in the same cycle
    step(6'h00, 0, 2'd2, 1, 32'h2, 0);
    step(6'h00, 0, 2'd0, 0, 32'h0, 0);
    step(6'h02, 0, 2'd0, 1, 32'h2, 0);
    peek(2'd0, 32'h2, "set_wins");

    // Reset while a level source stays high
    step(6'h01, 0, 2'd0, 0, 32'h0, 1);
    check("rst_mid_hw", {26'd0, HWInt}, 32'h00);
    peek(2'd0, 32'h0, "rst_mid_pend");
    step(6'h01, 0, 2'd0, 0, 32'h0, 0);
    check("rst_rel_hw", {26'd0, HWInt}, 32'h01);

    // Random traffic
    rs = 6'h00;
    for (int n = 0; n < 2000; n++) begin
      if (($urandom % 3) == 0) rs = 6'($urandom);
      step(rs, ($urandom % 4) == 0, 2'($urandom), ($urandom % 5) == 0, $urandom,
           ($urandom % 97) == 0);
    end

    // ACKCNT saturation and clear-wins
    step(6'h01, 0, 2'd0, 0, 32'h0, 1);
    step(6'h01, 0, 2'd0, 0, 32'h0, 0);
    for (int n = 0; n < 65535; n++) step(6'h01, 1, 2'd3, 0, 32'h0, 0);
    peek(2'd3, 32'hFFFF_0008, "sat_full");
    step(6'h01, 1, 2'd3, 0, 32'h0, 0);
    peek(2'd3, 32'hFFFF_0008, "sat_hold");
    step(6'h01, 1, 2'd3, 1, 32'h0, 0);
    peek(2'd3, 32'h0000_0008, "stat_clr");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/int_sched.md
Name: int_sched

Overview:
- Memory-mapped interrupt controller between the interrupt sources (TC0 IRQ, TC1 IRQ, external `interrupt`, three spare lines) and the CPU `HWInt` inputs.
- Latches, masks and prioritises the six hardware interrupt lines.
- Counts interrupts the CPU accepts; auto-acknowledges edge sources on `Intrespon`.
- Sits beside the TCs on the Bridge; the Bridge decodes one 16-byte window and routes word accesses here.

Parameters:
- NSRC, 6, number of interrupt source lines (fixed by `HWInt` width).
- RESET_MASK, 6'h3F, MASK register value after reset.
- RESET_EDGE, 6'h00, EDGE register value after reset (0 = level mode).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- irq_src  input  NSRC  raw source lines: {3'b0, interrupt, IRQ_1, IRQ_0}
- Intrespon  input  1  one-cycle pulse, CPU is entering the handler this cycle
- Addr  input  2  word offset within the window (byte address [3:2])
- WE  input  1  register write strobe
- Din  input  32  write data
- Dout  output  32  read data for Addr (combinational)
- HWInt  output  NSRC  interrupt request vector to CPU

Behaviour:
- Clock and reset:
  - Single clock `clk`; all state updates on the rising edge.
  - `reset` is synchronous and active-high. It overrides every other event in the same cycle.
  - Reset values: PEND=0, MASK=RESET_MASK, EDGE=RESET_EDGE, src_q=0, ACKCNT=0, HWInt=0.
- Register map (word offsets):
  - 0 PEND: read-only status. Writing 1 to a bit clears that bit (W1C).
  - 1 MASK: RW bits [5:0]; 1 = enabled.
  - 2 EDGE: RW bits [5:0]; 1 = edge-triggered, 0 = level-triggered.
  - 3 STAT: read returns {ACKCNT[15:0], 12'b0, valid, id[2:0]}. Any write clears ACKCNT.
  - Unused bits read 0.
- Source sampling: `src_q <= irq_src` every cycle.
- Level-mode bit i: `PEND[i] <= irq_src[i]`. W1C and auto-ack have no lasting effect on a level-mode bit.
- Edge-mode bit i:
  - Set when `irq_src[i] & ~src_q[i]` (rising edge).
  - Stays set until W1C or auto-ack.
  - A set and a clear in the same cycle: set wins.
- Switching a bit from edge to level takes effect next cycle; PEND then follows the source.
- Selection:
  - `act = PEND & MASK`.
  - `valid = |act`.
  - `id` = lowest index set in `act`; id = 0 when not valid.
- HWInt is combinational from the registered PEND and MASK. Latency from source to HWInt is exactly 1 clock.
- Intrespon:
  - On a cycle with `Intrespon=1` and `valid=1`, ACKCNT increments; it saturates at 16'hFFFF.
  - If `EDGE[id]=1`, `PEND[id]` is cleared on the same edge (auto-ack), unless a new edge on that source arrives in the same cycle.
  - `Intrespon` with `valid=0` does nothing.
- Simultaneous write to STAT and counted Intrespon: the clear wins, ACKCNT=0.
- Writes to MASK or EDGE take effect on the next edge. Dout reflects the new value in the following cycle.
- Reset mid-pending: all pending requests are discarded. A source held high in level mode re-asserts HWInt one cycle after reset deasserts.

Optional Feature:
- Macro: INTC_PRIORITY_EN.
- Defined: HWInt is one-hot `act[id]`, so only the highest-priority enabled pending source is presented (HWInt=0 when not valid).
- Undefined: HWInt = PEND & MASK, so all enabled pending sources are presented and the CPU's CP0 does the prioritising.
- STAT id/valid and auto-ack use the same lowest-index rule in both builds.

Test Plan:
- Reset, then hold irq_src=6'b000001 (level) → HWInt=6'b000001 one cycle later; drop the source → HWInt=0 one cycle later; STAT reads 0x0000_0008.
- Write EDGE=6'h04; pulse irq_src[2] for 1 cycle → PEND=6'h04 and it stays; write PEND=6'h04 → PEND=0 next cycle.
- EDGE=6'h03, pulse irq_src[0] and irq_src[1] together; with INTC_PRIORITY_EN, HWInt=6'h01; pulse Intrespon → PEND=6'h02, HWInt=6'h02, ACKCNT=1; pulse Intrespon again → PEND=0, ACKCNT=2.
- MASK=6'h3E with level irq_src[0]=1 → HWInt=0, STAT.valid=0; write MASK=6'h3F → HWInt=6'h01 on the next cycle.
- Edge source: rising edge on irq_src[1] in the same cycle as a W1C of PEND bit 1 → PEND[1]=1 (set wins).
- Preload ACKCNT=16'hFFFF by 65535 acks, then one more ack → stays 16'hFFFF; write STAT while Intrespon=1 → ACKCNT=0.
